load_store_unit: RTL and testbench

Data-side stage directly downstream of the core pipeline. It accepts one load/store request at a time, maps it onto the word-organised, byte-array data memory port (4 byte lanes, little-endian), and returns sign- or zero-extended load data. It generates byte-lane enables, waits a fixed memory read latency, and flags misaligned accesses.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage that maps byte/half/word requests onto a 4-lane little-endian word memory.
// Optional build macro LSU_MISALIGNED_SPLIT_EN splits misaligned half/word accesses into two word accesses.
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_byte_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_data_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic [2:0] ISSUE2 = 3'd4;
  localparam logic [2:0] WAIT2  = 3'd5;
`endif

  logic [2:0]  state;
  logic        write_q;
  logic        unsigned_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] word_addr;
  logic [31:0] data_lo;
  logic [3:0]  cnt;

  logic        accept;
  logic        misaligned;
  logic        req_err;
  logic [3:0]  size_mask;
  logic [31:0] wdata_masked;
  logic [31:0] load_raw;
  logic [31:0] load_ext;

  assign req_ready  = (state == IDLE) && !halted;
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    size_mask = 4'b0000;
    case (size_q)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      2'd2:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  // Drop store bytes beyond the access size so unused lanes read as zero.
  assign wdata_masked = wdata_q & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                   {8{size_mask[1]}}, {8{size_mask[0]}}};

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [31:0] data_hi;
  logic [7:0]  mask_wide;
  logic [63:0] data_wide;

  assign req_err   = (req_size == 2'd3);
  assign mask_wide = {4'b0000, size_mask} << off_q;
  assign data_wide = {32'b0, wdata_masked} << {off_q, 3'b000};

  always_comb begin
    mem_write_en = 1'b0;
    mem_byte_en  = 4'b0000;
    mem_data_in  = 32'b0;
    if (write_q && state == ISSUE) begin
      mem_write_en = 1'b1;
      mem_byte_en  = mask_wide[3:0];
      mem_data_in  = data_wide[31:0];
    end else if (write_q && state == ISSUE2) begin
      mem_write_en = 1'b1;
      mem_byte_en  = mask_wide[7:4];
      mem_data_in  = data_wide[63:32];
    end
  end

  // Both captured words form a little-endian 8-byte window; the access starts at off.
  assign load_raw = 32'({data_hi, data_lo} >> {off_q, 3'b000});
`else
  assign req_err      = (req_size == 2'd3) || misaligned;
  assign mem_write_en = write_q && (state == ISSUE);
  assign mem_byte_en  = mem_write_en ? (size_mask << off_q) : 4'b0000;
  assign mem_data_in  = mem_write_en ? (wdata_masked << {off_q, 3'b000}) : 32'b0;
  assign load_raw     = data_lo >> {off_q, 3'b000};
`endif

  always_comb begin
    load_ext = load_raw;
    case (size_q)
      2'd0:    load_ext = {{24{!unsigned_q && load_raw[7]}}, load_raw[7:0]};
      2'd1:    load_ext = {{16{!unsigned_q && load_raw[15]}}, load_raw[15:0]};
      default: load_ext = load_raw;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? load_ext : 32'b0;
  assign mem_addr   = word_addr;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      wdata_q    <= 32'b0;
      word_addr  <= 32'b0;
      data_lo    <= 32'b0;
      cnt        <= 4'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
      data_hi    <= 32'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            err_q      <= req_err;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q    <= misaligned;
`endif
            // Errors leave the memory port untouched, including its address.
            if (req_err) begin
              state <= RESP;
            end else begin
              word_addr <= {req_addr[31:2], 2'b00};
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (split_q) begin
              word_addr <= word_addr + 32'd4;
              state     <= ISSUE2;
            end else begin
              state <= RESP;
            end
`else
            state <= RESP;
`endif
          end else begin
            cnt   <= 4'(MEM_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            data_lo <= mem_data_out;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (split_q) begin
              word_addr <= word_addr + 32'd4;
              state     <= ISSUE2;
            end else begin
              state <= RESP;
            end
`else
            state <= RESP;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ISSUE2: begin
          if (write_q) begin
            state <= RESP;
          end else begin
            cnt   <= 4'(MEM_LATENCY - 1);
            state <= WAIT2;
          end
        end
        WAIT2: begin
          if (cnt == 4'd0) begin
            data_hi <= mem_data_out;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences for
// back-to-back/halt/reset corners, and random traffic against a byte-array memory model.
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        halted = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic [31:0] mem_data_out = 32'b0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_byte_en;
  logic        mem_write_en;

  int n_checks = 0;
  int n_fail = 0;
  int wr_pulses = 0;
  int resp_pulses = 0;

  logic [7:0] mem [0:1023];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_be;
    logic [31:0] e_din;
  } vec_t;

  vec_t tbl [14];

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_byte_en(mem_byte_en), .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mem_write_en) wr_pulses++;
    if (resp_valid) resp_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd3) ? 0 : (1 << sz);
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    logic [31:0] v;
    logic [9:0] idx;
    int n;
    n = nbytes(sz);
    v = 32'b0;
    for (int i = 0; i < n; i++) begin
      idx = 10'(a + 32'(i));
      v = v | (32'(mem[idx]) << (8 * i));
    end
    if (!u && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] din);
    int k;
    be = 4'b0;
    din = 32'b0;
    for (int i = 0; i < nbytes(sz); i++) begin
      k = (int'(a[1:0]) + i) % 4;
      be[k] = 1'b1;
      din[8 * k +: 8] = wd[8 * i +: 8];
    end
  endtask

  task automatic mem_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] idx;
    for (int i = 0; i < nbytes(sz); i++) begin
      idx = 10'(a + 32'(i));
      mem[idx] = wd[8 * i +: 8];
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] wa);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8 * k +: 8] = mem[{wa[9:2], 2'(k)}];
    return r;
  endfunction

  // Entered just after a negedge with the unit idle; returns at the negedge after the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input logic [3:0] e_be, input logic [31:0] e_din,
                        input logic halt_mid, input string tag);
    int rc;
    logic st;
    logic [31:0] word;
    word = {a[31:2], 2'b00};
    rc = e_err ? 1 : (w ? 2 : 2 + LAT);
    #1;
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= rc + 1; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (halt_mid && c == 1) halted = 1'b1;
      mem_data_out = (c == 1 + LAT && !w && !e_err) ? lanes(word) : $urandom;
      #1;
      chk($sformatf("%s.c%0d.ready", tag, c), 32'(req_ready), (c <= rc) ? 32'd0 : 32'(!halted));
      chk($sformatf("%s.c%0d.resp_valid", tag, c), 32'(resp_valid), 32'(c == rc));
      if (c == rc) begin
        chk($sformatf("%s.resp_err", tag), 32'(resp_err), 32'(e_err));
        chk($sformatf("%s.resp_rdata", tag), resp_rdata, e_rd);
      end
      st = (c == 1 && w && !e_err);
      chk($sformatf("%s.c%0d.wen", tag, c), 32'(mem_write_en), 32'(st));
      chk($sformatf("%s.c%0d.be", tag, c), 32'(mem_byte_en), st ? 32'(e_be) : 32'd0);
      if (st) chk($sformatf("%s.din", tag), mem_data_in, e_din);
      if (!e_err && c < rc) chk($sformatf("%s.c%0d.mem_addr", tag, c), mem_addr, word);
    end
    halted = 1'b0;
    if (w && !e_err) mem_write(sz, a, wd);
  endtask

  initial begin
    int pw;
    int pr;
    logic w;
    logic u;
    logic hm;
    logic e;
    logic [1:0] sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic [3:0] be;
    logic [31:0] din;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        1'b0, 32'hFFFFFFDE, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        1'b0, 32'h000000DE, 4'h0, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        1'b0, 32'hFFFFDEAD, 4'h0, 32'h0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h105, 32'h12345677, 1'b0, 32'h0,        4'h2, 32'h00007700};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h10A, 32'hCAFE8001, 1'b0, 32'h0,        4'hC, 32'h80010000};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h10A, 32'h0,        1'b0, 32'hFFFF8001, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h10A, 32'h0,        1'b0, 32'h00008001, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 32'h200, 32'h55555555, 1'b1, 32'h0,        4'h0, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h101, 32'h0000AAAA, 1'b1, 32'h0,        4'h0, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        1'b0, 32'hFFFFFFEF, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        1'b0, 32'h000000BE, 4'h0, 32'h0};

    // Reset values, asynchronously before any clock edge.
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.din", mem_data_in, 32'd0);
    chk("rst.be", 32'(mem_byte_en), 32'd0);
    chk("rst.wen", 32'(mem_write_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;

    for (int i = 0; i < 14; i++)
      do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].e_err,
             tbl[i].e_rd, tbl[i].e_be, tbl[i].e_din, 1'b0, $sformatf("vec%0d", i));

    // Halted raised mid-access: the load still completes.
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 1'b1, "halt_mid");

    // Back-to-back: second request held from cycle 1, accepted exactly once.
    #1;
    pw = wr_pulses; pr = resp_pulses;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h204; req_wdata = 32'h22222222;
    #1 chk("b2b.c1.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1 chk("b2b.c2.ready", 32'(req_ready), 32'd0);
    chk("b2b.c2.resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    #1 chk("b2b.c3.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("b2b.c4.mem_addr", mem_addr, 32'h204);
    chk("b2b.c4.wen", 32'(mem_write_en), 32'd1);
    chk("b2b.c4.din", mem_data_in, 32'h22222222);
    repeat (4) @(negedge clk);
    #1 chk("b2b.wr_pulses", 32'(wr_pulses - pw), 32'd2);
    chk("b2b.resp_pulses", 32'(resp_pulses - pr), 32'd2);
    chk("b2b.ready_after", 32'(req_ready), 32'd1);
    mem_write(2'd2, 32'h200, 32'h11111111);
    mem_write(2'd2, 32'h204, 32'h22222222);

    // Halted while idle: nothing is accepted.
    pw = wr_pulses; pr = resp_pulses;
    halted = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300;
    #1 chk("halt.ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1 chk("halt.ready_later", 32'(req_ready), 32'd0);
    chk("halt.wr_pulses", 32'(wr_pulses - pw), 32'd0);
    chk("halt.resp_pulses", 32'(resp_pulses - pr), 32'd0);
    req_valid = 1'b0; halted = 1'b0;
    @(negedge clk);

    // Reset asserted during WAIT aborts the load with no response.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 rst_b = 1'b1;
    #1;
    chk("arst.ready", 32'(req_ready), 32'd1);
    chk("arst.resp_valid", 32'(resp_valid), 32'd0);
    chk("arst.mem_addr", mem_addr, 32'd0);
    chk("arst.be", 32'(mem_byte_en), 32'd0);
    chk("arst.wen", 32'(mem_write_en), 32'd0);
    pr = resp_pulses;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    #1 chk("arst.no_resp", 32'(resp_pulses - pr), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0, "post_rst");

    // Random traffic against the byte-array model.
    for (int t = 0; t < 60; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      u  = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~(32'(nbytes(sz)) - 32'd1);
      wd = $urandom;
      hm = ($urandom_range(0, 7) == 0);
      e  = model_err(sz, a);
      erd = (w || e) ? 32'd0 : model_load(sz, u, a);
      model_store(sz, a, wd, be, din);
      do_req(w, sz, u, a, wd, e, erd, be, din, hm, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
